// File: rtl/rgb_fade_pkg.sv
// Shared types and constants for the RGB fade sequencer.
// Holds the gamma curve used when RGB_FADE_GAMMA_EN is defined.
package rgb_fade_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    localparam int CHAN_W = 8;
    localparam int CMD_W  = 24;

    // Bit positions of each channel inside the packed {R,G,B} command word
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // Approximate square-law curve: (v*v + 255) >> 8 keeps 0->0, 1->1 and 255->255
    function automatic logic [CHAN_W-1:0] gamma(input logic [CHAN_W-1:0] v);
        logic [2*CHAN_W-1:0] v_wide;
        logic [2*CHAN_W-1:0] sq;
        v_wide = {{CHAN_W{1'b0}}, v};
        sq     = v_wide * v_wide + 16'd255;
        return sq[2*CHAN_W-1:CHAN_W];
    endfunction

endpackage

// File: rtl/rgb_fade_ctrl_if.sv
// Command port of the fade sequencer: valid/ready handshake carrying a target
// colour and the instant-jump qualifier.
interface rgb_fade_ctrl_if;
    import rgb_fade_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_rgb;
    logic              cmd_instant;

    modport master (
        output cmd_valid,
        output cmd_rgb,
        output cmd_instant,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rgb,
        input  cmd_instant,
        output cmd_ready
    );

endinterface

// File: rtl/rgb_fade_chan.sv
// One colour channel: holds current and target value and computes the
// saturating step toward target using 9-bit arithmetic.
module rgb_fade_chan
    import rgb_fade_pkg::*;
#(
    parameter int STEP_SIZE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_jump,
    input  logic              i_step,
    input  logic [CHAN_W-1:0] i_tgt,
    output logic [CHAN_W-1:0] o_nxt,
    output logic              o_at_target,
    output logic              o_eq_cmd
);

    localparam logic [CHAN_W:0] STEP9 = (CHAN_W+1)'(STEP_SIZE);

    logic [CHAN_W-1:0] r_cur;
    logic [CHAN_W-1:0] r_tgt;

    logic [CHAN_W:0]   w_cur9;
    logic [CHAN_W:0]   w_tgt9;
    logic [CHAN_W:0]   w_up9;
    logic [CHAN_W:0]   w_dn9;
    logic [CHAN_W:0]   w_dn_lim9;
    logic [CHAN_W-1:0] w_step_val;
    logic [CHAN_W-1:0] w_nxt;

    assign w_cur9    = {1'b0, r_cur};
    assign w_tgt9    = {1'b0, r_tgt};
    assign w_up9     = w_cur9 + STEP9;
    assign w_dn9     = w_cur9 - STEP9;
    assign w_dn_lim9 = w_tgt9 + STEP9;

    // Clamp to target whenever a full step would reach or pass it
    always_comb begin
        w_step_val = r_cur;
        if (r_tgt > r_cur) begin
            w_step_val = (w_up9 >= w_tgt9) ? r_tgt : w_up9[CHAN_W-1:0];
        end else if (r_tgt < r_cur) begin
            w_step_val = (w_cur9 <= w_dn_lim9) ? r_tgt : w_dn9[CHAN_W-1:0];
        end
    end

    assign w_nxt       = i_jump ? i_tgt : (i_step ? w_step_val : r_cur);
    assign o_nxt       = w_nxt;
    assign o_at_target = (w_nxt == r_tgt);
    assign o_eq_cmd    = (i_tgt == r_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
            r_tgt <= '0;
        end else begin
            r_cur <= w_nxt;
            if (i_load) begin
                r_tgt <= i_tgt;
            end
        end
    end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB fade sequencer: jumps or fades linearly to commanded colours and drives
// the PWM duty values with a shared load strobe. Optional macro RGB_FADE_GAMMA_EN
// applies a square-law curve to the registered outputs.
module rgb_fade_ctrl
    import rgb_fade_pkg::*;
#(
    parameter int STEP_CYCLES = 1024,
    parameter int STEP_SIZE   = 1
) (
    input  logic               clk,
    input  logic               rst,
    rgb_fade_ctrl_if.slave     cmd,
    input  logic               abort,
    output logic [CHAN_W-1:0]  r_value,
    output logic [CHAN_W-1:0]  g_value,
    output logic [CHAN_W-1:0]  b_value,
    output logic               pwm_en,
    output logic               busy,
    output logic               done
);

    localparam logic [15:0] PRESC_LAST = 16'(STEP_CYCLES - 1);

    state_t            r_state;
    logic [15:0]       r_presc;
    logic              r_fin_pend;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_pwm_en;
    logic [CHAN_W-1:0] r_r_value;
    logic [CHAN_W-1:0] r_g_value;
    logic [CHAN_W-1:0] r_b_value;

    logic              w_accept;
    logic              w_same;
    logic              w_jump;
    logic              w_tc;
    logic              w_step;
    logic              w_all_at;
    logic [2:0]        w_eq;
    logic [2:0]        w_at;
    logic [CHAN_W-1:0] w_r_nxt;
    logic [CHAN_W-1:0] w_g_nxt;
    logic [CHAN_W-1:0] w_b_nxt;

    function automatic logic [CHAN_W-1:0] out_map(input logic [CHAN_W-1:0] v);
`ifdef RGB_FADE_GAMMA_EN
        return gamma(v);
`else
        return v;
`endif
    endfunction

    assign w_accept = cmd.cmd_valid && (r_state == IDLE);
    assign w_same   = &w_eq;
    assign w_jump   = w_accept && (cmd.cmd_instant || w_same);
    assign w_tc     = (r_state == FADE) && (r_presc == PRESC_LAST);
    // The cycle after the final step is spent in FADE only to retire it
    assign w_step   = w_tc && !abort && !r_fin_pend;
    assign w_all_at = &w_at;

    rgb_fade_chan #(.STEP_SIZE(STEP_SIZE)) u_chan_r (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_jump      (w_jump),
        .i_step      (w_step),
        .i_tgt       (cmd.cmd_rgb[R_LSB +: CHAN_W]),
        .o_nxt       (w_r_nxt),
        .o_at_target (w_at[2]),
        .o_eq_cmd    (w_eq[2])
    );

    rgb_fade_chan #(.STEP_SIZE(STEP_SIZE)) u_chan_g (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_jump      (w_jump),
        .i_step      (w_step),
        .i_tgt       (cmd.cmd_rgb[G_LSB +: CHAN_W]),
        .o_nxt       (w_g_nxt),
        .o_at_target (w_at[1]),
        .o_eq_cmd    (w_eq[1])
    );

    rgb_fade_chan #(.STEP_SIZE(STEP_SIZE)) u_chan_b (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_jump      (w_jump),
        .i_step      (w_step),
        .i_tgt       (cmd.cmd_rgb[B_LSB +: CHAN_W]),
        .o_nxt       (w_b_nxt),
        .o_at_target (w_at[0]),
        .o_eq_cmd    (w_eq[0])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_fin_pend  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pwm_en    <= 1'b0;
            r_r_value   <= '0;
            r_g_value   <= '0;
            r_b_value   <= '0;
        end else begin
            r_r_value <= out_map(w_r_nxt);
            r_g_value <= out_map(w_g_nxt);
            r_b_value <= out_map(w_b_nxt);
            r_pwm_en  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_jump) begin
                            r_pwm_en <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_state     <= FADE;
                            r_presc     <= '0;
                            r_fin_pend  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                FADE: begin
                    if (abort || r_fin_pend) begin
                        r_state     <= IDLE;
                        r_presc     <= '0;
                        r_fin_pend  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else if (w_tc) begin
                        r_presc  <= '0;
                        r_pwm_en <= 1'b1;
                        if (w_all_at) begin
                            r_done     <= 1'b1;
                            r_fin_pend <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready = r_cmd_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pwm_en        = r_pwm_en;
    assign r_value       = r_r_value;
    assign g_value       = r_g_value;
    assign b_value       = r_b_value;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: two instances (STEP_SIZE 1 and 16) share stimulus and
// are checked every cycle against a colour-level model plus hand-computed points.
module tb_rgb_fade_ctrl;

    localparam int SC = 4;

`ifdef RGB_FADE_GAMMA_EN
    localparam int L2 = 1, L3 = 1, L128 = 64;
`else
    localparam int L2 = 2, L3 = 3, L128 = 128;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic [23:0] t_rgb;
    logic        t_inst;
    logic        vld [2];
    logic        rdy [2];
    logic [7:0]  rv [2];
    logic [7:0]  gv [2];
    logic [7:0]  bv [2];
    logic        pe [2];
    logic        bz [2];
    logic        dn [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_on = 0;
    int acc [2];

    // Model: linear colour per instance, fade bookkeeping by elapsed cycles
    int m_cur [2][3];
    int m_tgt [2][3];
    bit m_fade [2];
    bit m_fin [2];
    int m_e [2];
    bit e_pe [2];
    bit e_dn [2];

    always #5 clk = ~clk;

    rgb_fade_ctrl_if c0 ();
    rgb_fade_ctrl_if c1 ();

    assign c0.cmd_valid   = vld[0];
    assign c0.cmd_rgb     = t_rgb;
    assign c0.cmd_instant = t_inst;
    assign c1.cmd_valid   = vld[1];
    assign c1.cmd_rgb     = t_rgb;
    assign c1.cmd_instant = t_inst;
    assign rdy[0] = c0.cmd_ready;
    assign rdy[1] = c1.cmd_ready;

    rgb_fade_ctrl #(.STEP_CYCLES(SC), .STEP_SIZE(1)) dut0 (
        .clk(clk), .rst(rst), .cmd(c0), .abort(abort),
        .r_value(rv[0]), .g_value(gv[0]), .b_value(bv[0]),
        .pwm_en(pe[0]), .busy(bz[0]), .done(dn[0])
    );

    rgb_fade_ctrl #(.STEP_CYCLES(SC), .STEP_SIZE(16)) dut1 (
        .clk(clk), .rst(rst), .cmd(c1), .abort(abort),
        .r_value(rv[1]), .g_value(gv[1]), .b_value(bv[1]),
        .pwm_en(pe[1]), .busy(bz[1]), .done(dn[1])
    );

    function automatic int ss(input int d);
        return (d == 0) ? 1 : 16;
    endfunction

    function automatic int gam(input int v);
`ifdef RGB_FADE_GAMMA_EN
        return (v * v + 255) / 256;
`else
        return v;
`endif
    endfunction

    function automatic int cmd_ch(input logic [23:0] c, input int ch);
        return int'(c[23 - 8*ch -: 8]);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    m_cur[d][ch] = 0;
                    m_tgt[d][ch] = 0;
                end
                m_fade[d] = 0; m_fin[d] = 0; m_e[d] = 0;
                e_pe[d] = 0; e_dn[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit same;
                bit all_eq;
                e_pe[d] = 0;
                e_dn[d] = 0;
                if (!m_fade[d]) begin
                    if (vld[d]) begin
                        same = 1;
                        for (int ch = 0; ch < 3; ch++) begin
                            m_tgt[d][ch] = cmd_ch(t_rgb, ch);
                            if (m_tgt[d][ch] != m_cur[d][ch]) same = 0;
                        end
                        if (t_inst || same) begin
                            for (int ch = 0; ch < 3; ch++) m_cur[d][ch] = m_tgt[d][ch];
                            e_pe[d] = 1;
                            e_dn[d] = 1;
                        end else begin
                            m_fade[d] = 1; m_fin[d] = 0; m_e[d] = 0;
                        end
                    end
                end else if (m_fin[d] || abort) begin
                    m_fade[d] = 0;
                end else begin
                    m_e[d]++;
                    if (m_e[d] % SC == 0) begin
                        all_eq = 1;
                        for (int ch = 0; ch < 3; ch++) begin
                            int diff;
                            diff = m_tgt[d][ch] - m_cur[d][ch];
                            if (diff > ss(d)) m_cur[d][ch] += ss(d);
                            else if (diff < -ss(d)) m_cur[d][ch] -= ss(d);
                            else m_cur[d][ch] = m_tgt[d][ch];
                            if (m_cur[d][ch] != m_tgt[d][ch]) all_eq = 0;
                        end
                        e_pe[d] = 1;
                        if (all_eq) begin
                            e_dn[d] = 1;
                            m_fin[d] = 1;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d_r", d), 32'(rv[d]), 32'(gam(m_cur[d][0])));
                check($sformatf("d%0d_g", d), 32'(gv[d]), 32'(gam(m_cur[d][1])));
                check($sformatf("d%0d_b", d), 32'(bv[d]), 32'(gam(m_cur[d][2])));
                check($sformatf("d%0d_pwm_en", d), 32'(pe[d]), 32'(e_pe[d]));
                check($sformatf("d%0d_done", d), 32'(dn[d]), 32'(e_dn[d]));
                check($sformatf("d%0d_busy", d), 32'(bz[d]), 32'(m_fade[d]));
                check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(!m_fade[d]));
            end
        end
    end

    task automatic send(input logic [23:0] rgb, input logic inst);
        bit pend [2];
        @(posedge clk);
        #1;
        t_rgb = rgb; t_inst = inst; vld[0] = 1'b1; vld[1] = 1'b1;
        for (int k = 0; k < 400 && (vld[0] || vld[1]); k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) pend[d] = vld[d] && rdy[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) begin
                    vld[d] = 1'b0;
                    acc[d] = cyc;
                end
            end
        end
        if (vld[0] || vld[1]) begin
            check("send_timeout", 32'd1, 32'd0);
            vld[0] = 1'b0; vld[1] = 1'b0;
        end
        t_inst = 1'b0;
    endtask

    task automatic wait_after(input int n);
        while (cyc < n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (k < 3000 && (bz[0] || bz[1] || !rdy[0] || !rdy[1])) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; abort = 1'b0; t_rgb = '0; t_inst = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_on = 1;

        @(negedge clk);
        check("rst_r", 32'(rv[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_busy", 32'(bz[0]), 32'd0);
        check("rst_pwm_en", 32'(pe[0]), 32'd0);

        // Same colour without instant still takes the jump path
        send(24'h000000, 1'b0); n = acc[0];
        wait_after(n);
        check("same_pwm_en", 32'(pe[0]), 32'd1);
        check("same_done", 32'(dn[0]), 32'd1);
        check("same_busy", 32'(bz[0]), 32'd0);

        send(24'h030001, 1'b0); n = acc[0];
        wait_after(n);
        check("fade_busy_n1", 32'(bz[0]), 32'd1);
        check("fade_ready_n1", 32'(rdy[0]), 32'd0);
        wait_after(n + 3);
        check("fade_no_step_n4", 32'(pe[0]), 32'd0);
        wait_after(n + 4);
        check("fade_s1_r", 32'(rv[0]), 32'd1);
        check("fade_s1_b", 32'(bv[0]), 32'd1);
        check("fade_s1_pwm", 32'(pe[0]), 32'd1);
        check("fade_s1_done", 32'(dn[0]), 32'd0);
        check("fade16_r", 32'(rv[1]), 32'(L3));
        check("fade16_done", 32'(dn[1]), 32'd1);
        wait_after(n + 8);
        check("fade_s2_r", 32'(rv[0]), 32'(L2));
        check("fade_s2_pwm", 32'(pe[0]), 32'd1);
        wait_after(n + 12);
        check("fade_s3_r", 32'(rv[0]), 32'(L3));
        check("fade_s3_done", 32'(dn[0]), 32'd1);
        check("fade_s3_busy", 32'(bz[0]), 32'd1);
        wait_after(n + 13);
        check("fade_end_busy", 32'(bz[0]), 32'd0);
        check("fade_end_ready", 32'(rdy[0]), 32'd1);

        send(24'h000000, 1'b1);
        wait_idle();
        send(24'h030000, 1'b0); n = acc[0];
        wait_after(n + 8);
        check("abort_pre_r", 32'(rv[0]), 32'(L2));
        while (cyc < n + 11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_r", 32'(rv[0]), 32'(L2));
        check("abort_pwm_en", 32'(pe[0]), 32'd0);
        check("abort_done", 32'(dn[0]), 32'd0);
        check("abort_ready", 32'(rdy[0]), 32'd1);
        check("abort_idle16_r", 32'(rv[1]), 32'(L3));

        send(24'hFF8000, 1'b1); n = acc[0];
        wait_after(n);
        check("inst_r", 32'(rv[0]), 32'd255);
        check("inst_g", 32'(gv[0]), 32'(L128));
        check("inst_b", 32'(bv[0]), 32'd0);
        check("inst_pwm_en", 32'(pe[0]), 32'd1);
        check("inst_done", 32'(dn[0]), 32'd1);
        check("inst_ready", 32'(rdy[0]), 32'd1);
        wait_after(n + 1);
        check("inst_pwm_en_off", 32'(pe[0]), 32'd0);
        check("inst_done_off", 32'(dn[0]), 32'd0);

        send({8'd250, 8'd0, 8'd10}, 1'b1);
        wait_idle();
        send(24'hFF0000, 1'b0); n = acc[0];
        wait_after(n + 4);
        check("sat16_r", 32'(rv[1]), 32'd255);
        check("sat16_b", 32'(bv[1]), 32'd0);
        check("sat16_done", 32'(dn[1]), 32'd1);
        wait_idle();

        send(24'h000000, 1'b1);
        wait_idle();
        send(24'h000003, 1'b0); n = acc[0];
        send(24'h000000, 1'b1);
        check("bp_accept_ss1", 32'(acc[0] - n), 32'd14);
        check("bp_accept_ss16", 32'(acc[1] - n), 32'd6);

        wait_idle();
        send(24'h030000, 1'b0); n = acc[0];
        wait_after(n + 5);
        check("prerst_r", 32'(rv[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_r", 32'(rv[0]), 32'd0);
        check("arst_r16", 32'(rv[1]), 32'd0);
        check("arst_ready", 32'(rdy[0]), 32'd1);
        check("arst_busy", 32'(bz[0]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        send(24'h80FF01, 1'b1); n = acc[0];
        wait_after(n);
        check("map_r", 32'(rv[0]), 32'(L128));
        check("map_g", 32'(gv[0]), 32'd255);
        check("map_b", 32'(bv[0]), 32'd1);

        @(negedge clk);
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
- Sequencer in front of the three 8-bit PWM channels (R, G, B).
- Accepts target colours over a valid/ready command port and either jumps to them or fades linearly toward them.
- Drives per-channel duty values plus a single load strobe (pwm_en) that all three pwm channels sample on their enable input.
- Sits between the SPI register file and the pwm instances.

Parameters:
- STEP_CYCLES, 1024: clocks between fade steps; legal range 1..65535.
- STEP_SIZE, 1: maximum change per channel per step; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_rgb  in  24  target colour, {R[23:16], G[15:8], B[7:0]}
- cmd_instant  in  1  qualifies cmd_valid: jump to target, no fade
- abort  in  1  stop an active fade, freeze current colour
- r_value  out  8  red duty value to pwm
- g_value  out  8  green duty value to pwm
- b_value  out  8  blue duty value to pwm
- pwm_en  out  1  one-cycle load strobe for all pwm channels
- busy  out  1  fade in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (clk and rst are fixed: one clock; reset asynchronous, active-high):
  - state=IDLE; current, target and prescaler = 0.
  - All value outputs = 0; pwm_en, busy and done = 0; cmd_ready = 1.
  - Reset asserted mid-fade clears everything immediately, without waiting for a clock edge.
- All outputs are registered. cmd_ready = (state==IDLE). busy = (state==FADE).
- Accept: cmd_valid & cmd_ready at a rising edge (cycle N) latches target = cmd_rgb.
- Instant path (cmd_instant=1, or target==current):
  - current = target; new values appear at N+1 with pwm_en=1 and done=1 for that cycle.
  - State remains IDLE.
- Fade path:
  - Enter FADE at N+1 with prescaler=0.
  - Prescaler counts 0..STEP_CYCLES-1, then wraps.
  - At terminal count, each channel moves toward its target by min(STEP_SIZE, |target-current|).
  - Step arithmetic uses 9 bits: no overshoot, no wrap past 0 or 255.
  - Updated values appear on the following cycle together with pwm_en=1, pulsed once per step for all channels.
  - First step is visible at N+STEP_CYCLES+1.
  - Step count = ceil(max channel distance / STEP_SIZE).
- Completion: the step that makes all channels equal their targets also asserts done (same cycle as its pwm_en); state returns to IDLE.
- Abort: in FADE, abort takes priority over a coincident step.
  - Values stay frozen; no pwm_en, no done.
  - IDLE and cmd_ready=1 from the next cycle.
  - abort is ignored in IDLE.
- cmd_valid during FADE is not accepted; the source holds the command. cmd_instant has no effect unless the command is accepted.
- pwm_en is never asserted without a value change, except on an instant command to the same colour.

Optional Feature:
- Macro RGB_FADE_GAMMA_EN.
- Defined: each output = (v*v + 255) >> 8 of the internal linear value v. This maps 0→0, 1→1, 128→64, 255→255. The result is computed into the same output register, with no added latency. Fading and completion still operate on linear values.
- Undefined: outputs equal the linear values.

Decomposition:
- Package rgb_fade_pkg:
  - state enum {IDLE, FADE}
  - CHAN_W=8, CMD_W=24
  - channel-index constants for R/G/B slice positions
  - gamma function
- Sub-module rgb_fade_chan, instantiated three times:
  - holds current and target for one channel
  - computes the saturating step toward target
  - outputs "at_target"

Test Plan (STEP_CYCLES=4, STEP_SIZE=1 unless stated):
- Instant load: cmd 0xFF8000 with instant=1, accepted cycle N → at N+1 r=255, g=128, b=0; pwm_en=1 and done=1 for exactly one cycle; cmd_ready stays 1.
- Fade: from 000000 to {3,0,1} → value triples (1,0,1), (2,0,1), (3,0,1) at N+5, N+9, N+13; three pwm_en pulses; done with the third; busy high N+1..N+13.
- Saturation (STEP_SIZE=16): 250→255 takes one step to 255; 10→0 takes one step to 0, no wrap; done with that step.
- Abort coincident with a step at value 2 (target 3) → value stays 2, no pwm_en, no done; cmd_ready=1 next cycle.
- Backpressure and reset: cmd_valid held during a fade is accepted only on the first IDLE cycle after done; asynchronous rst mid-fade forces all outputs to 0 and cmd_ready=1 before the next clock edge.
- RGB_FADE_GAMMA_EN: instant cmd 0x80FF01 → r=64, g=255, b=1.
